// File: rtl/spi_master_ctrl_if.sv
// Host-side handshake and SPI pin bundle for spi_master_ctrl.
// The controller uses the master modport; the host or bench drives through the slave modport.
interface spi_master_ctrl_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, wdata, MISO,
    output busy, done, rdata, rdata_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, wdata, MISO,
    input  busy, done, rdata, rdata_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master framing host commands {rd/wr, cmd, payload} for the SPI slave + RAM wrapper.
// A read-data frame is followed by a turnaround and an 8-bit MISO capture; one frame in flight.
module spi_master_ctrl #(
  parameter int TURN_CYCLES = 1,  // >= 1
  parameter int GAP_CYCLES  = 1   // >= 1
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SHIFT   = 3'd2,
    TURN    = 3'd3,
    CAPTURE = 3'd4,
    DESEL   = 3'd5
  } state_t;

  localparam logic [3:0] SHIFT_LAST   = 4'd10;
  localparam logic [3:0] CAPTURE_LAST = 4'd7;
  localparam logic [3:0] TURN_LAST    = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [10:0] frame;
  logic [3:0]  cnt;
  logic [7:0]  rx_sr;
  logic        is_rd_data;

  // NOTE: every register here is sequential state, so it is assigned with <= only;
  // blocking assignments would make later reads in this block see same-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      frame           <= '0;
      cnt             <= '0;
      rx_sr           <= '0;
      is_rd_data      <= 1'b0;
      bus.SS_n        <= 1'b1;
      bus.MOSI        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.rdata_valid <= 1'b0;
      bus.rdata       <= 8'h00;
    end else begin
      bus.done        <= 1'b0;
      bus.rdata_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            frame      <= {bus.cmd[1], bus.cmd, bus.wdata};
            is_rd_data <= (bus.cmd == 2'b11);
            bus.busy   <= 1'b1;
            bus.SS_n   <= 1'b0;
            bus.MOSI   <= 1'b0;
            cnt        <= '0;
            state      <= SELECT;
          end
        end

        SELECT: begin
          // Present frame[10] now; the frame register shifts left so bit 10 is always next.
          bus.MOSI <= frame[10];
          frame    <= {frame[9:0], 1'b0};
          cnt      <= '0;
          state    <= SHIFT;
        end

        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            bus.MOSI <= 1'b0;
            cnt      <= '0;
            if (is_rd_data) begin
              state <= TURN;
            end else begin
              bus.SS_n <= 1'b1;
              bus.done <= 1'b1;
              state    <= DESEL;
            end
          end else begin
            bus.MOSI <= frame[10];
            frame    <= {frame[9:0], 1'b0};
            cnt      <= cnt + 4'd1;
          end
        end

        TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        CAPTURE: begin
          rx_sr <= {rx_sr[6:0], bus.MISO};
          if (cnt == CAPTURE_LAST) begin
            bus.rdata       <= {rx_sr[6:0], bus.MISO};
            bus.rdata_valid <= 1'b1;
            bus.done        <= 1'b1;
            bus.SS_n        <= 1'b1;
            cnt             <= '0;
            state           <= DESEL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DESEL: begin
          // Start is still blocked in the last gap cycle because busy is high there.
          if (cnt == GAP_LAST) begin
            bus.busy <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          bus.SS_n <= 1'b1;
          bus.MOSI <= 1'b0;
          bus.busy <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: cycle-level frame model, SPI slave + RAM emulation,
// and a host-level scoreboard of RAM contents, driven by directed cases and a random regression.
module tb_spi_master_ctrl;
  localparam int TURN = 1;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input logic [1:0] c);
    return (c == 2'b11) ? 12 + TURN + 8 : 12;
  endfunction

  // Cycle model: t counts cycles since accept (0 = idle); outputs follow from t and the command.
  bit          mon_en = 1'b0;
  int          t = 0;
  int          m_len = 12;
  logic [1:0]  m_cmd = 2'b00;
  logic [7:0]  m_wdata = 8'h00;
  logic [10:0] m_frame;
  logic [7:0]  exp_rdata = 8'h00;
  logic [7:0]  pend_rd = 8'h00;
  logic [7:0]  sb_mem [256] = '{default: 8'h00};
  logic [7:0]  sb_waddr = 8'h00;
  logic [7:0]  sb_raddr = 8'h00;
  int          accepts = 0;
  int          done_cnt = 0;
  int          rdv_cnt = 0;
  int          busy_hi_cnt = 0;
  logic        e_ss, e_mosi, e_busy, e_done, e_rdv;
  logic [12:0] act_v, exp_v;

  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {bus.SS_n, bus.MOSI, bus.busy, bus.done, bus.rdata_valid, bus.rdata};
      if (bus.done === 1'b1)        done_cnt++;
      if (bus.rdata_valid === 1'b1) rdv_cnt++;
      if (bus.busy === 1'b1)        busy_hi_cnt++;

      if (rst) begin
        t         = 0;
        exp_rdata = 8'h00;
        exp_v     = 13'h1000;
      end else begin
        m_len   = frame_len(m_cmd);
        m_frame = {m_cmd[1], m_cmd, m_wdata};
        if (t == 0) begin
          e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdv = 1'b0;
        end else begin
          e_ss   = (t > m_len);
          e_mosi = (t >= 2 && t <= 12) ? m_frame[12 - t] : 1'b0;
          e_busy = 1'b1;
          e_done = (t == m_len + 1);
          e_rdv  = e_done && (m_cmd == 2'b11);
          if (e_rdv) exp_rdata = pend_rd;
        end
        exp_v = {e_ss, e_mosi, e_busy, e_done, e_rdv, exp_rdata};
      end
      check("cycle", 32'(act_v), 32'(exp_v));

      if (rst) begin
        t = 0;
      end else if (t == 0) begin
        if (bus.start) begin
          m_cmd   = bus.cmd;
          m_wdata = bus.wdata;
          accepts++;
          case (bus.cmd)
            2'b00: sb_waddr = bus.wdata;
            2'b01: sb_mem[sb_waddr] = bus.wdata;
            2'b10: sb_raddr = bus.wdata;
            default: pend_rd = sb_mem[sb_raddr];
          endcase
          t = 1;
        end
      end else begin
        t = (t == frame_len(m_cmd) + GAP) ? 0 : t + 1;
      end
    end
  end

  // SPI slave + RAM emulation: decodes MOSI, drives MISO only in the capture window.
  int          k = 0;
  logic [10:0] sh = '0;
  logic [7:0]  s_mem [256] = '{default: 8'h00};
  logic [7:0]  s_waddr = 8'h00;
  logic [7:0]  s_raddr = 8'h00;
  logic [7:0]  s_rbyte = 8'h00;
  int          last_len = 0;
  logic [10:0] last_bits = '0;
  int          high_run = 0;
  int          last_gap = 0;

  always @(negedge clk) begin
    if (bus.SS_n !== 1'b0) begin
      if (k > 0) begin
        last_len  = k;
        last_bits = sh;
        high_run  = 0;
      end
      high_run++;
      k = 0;
      bus.MISO = 1'($urandom_range(1, 0));
    end else begin
      if (k == 0) last_gap = high_run;
      k++;
      if (k >= 2 && k <= 12) sh = {sh[9:0], bus.MOSI};
      if (k == 12) begin
        case (sh[9:8])
          2'b00: s_waddr = sh[7:0];
          2'b01: s_mem[s_waddr] = sh[7:0];
          2'b10: s_raddr = sh[7:0];
          default: s_rbyte = s_mem[s_raddr];
        endcase
      end
      if (k > 12 && sh[9:8] == 2'b11 && k >= 13 + TURN && k <= 12 + TURN + 8)
        bus.MISO = s_rbyte[7 - (k - 13 - TURN)];
      else
        bus.MISO = 1'($urandom_range(1, 0));
    end
  end

  // All driver tasks start and end at posedge + 1.
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", 32'(bus.busy), 32'(1'b0));
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] w);
    wait_idle();
    bus.cmd   = c;
    bus.wdata = w;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cmd   = 2'($urandom_range(0, 3));
    bus.wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(bus.done), 32'(1'b1));
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  int d0, r0, b0, a0, n;

  initial begin
    bus.start = 1'b0;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h00;

    #2 rst = 1'b1;
    #1;
    mon_en = 1'b1;
    check("reset_outputs", 32'({bus.SS_n, bus.MOSI, bus.busy, bus.done, bus.rdata_valid, bus.rdata}), 32'(13'h1000));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Write-address A5: bit sequence and frame length are fixed by the frame format.
    d0 = done_cnt; r0 = rdv_cnt;
    send(2'b00, 8'hA5);
    wait_frame_end();
    check("a5_bits", 32'(last_bits), 32'(11'b000_1010_0101));
    check("a5_sslow_len", 32'(last_len), 32'd12);
    check("a5_done_count", 32'(done_cnt - d0), 32'd1);
    check("a5_rdv_count", 32'(rdv_cnt - r0), 32'd0);

    // Write 5A at 3C then read it back.
    send(2'b00, 8'h3C); wait_frame_end();
    send(2'b01, 8'h5A); wait_frame_end();
    send(2'b10, 8'h3C); wait_frame_end();
    r0 = rdv_cnt;
    send(2'b11, 8'hFF); wait_frame_end();
    check("readback_rdata", 32'(bus.rdata), 32'h5A);
    check("readback_sslow_len", 32'(last_len), 32'd21);
    check("readback_rdv_count", 32'(rdv_cnt - r0), 32'd1);

    // start held high for the whole frame: one frame, busy continuous.
    wait_idle();
    d0 = done_cnt; b0 = busy_hi_cnt;
    bus.cmd = 2'b00; bus.wdata = 8'h11; bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus.busy && n < 100) begin
      bus.cmd   = 2'($urandom_range(0, 3));
      bus.wdata = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      n++;
    end
    check("held_start_done_count", 32'(done_cnt - d0), 32'd1);
    check("held_start_busy_cycles", 32'(busy_hi_cnt - b0), 32'(12 + GAP));

    // Back-to-back: new start the very cycle busy is seen low.
    bus.cmd = 2'b01; bus.wdata = 8'h77; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_frame_end();
    check("b2b_gap_ok", 32'(last_gap >= GAP), 32'd1);
    check("b2b_sslow_len", 32'(last_len), 32'd12);

    // Reset in the middle of a read-data capture.
    send(2'b11, 8'h00);
    n = 0;
    while (k < 16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("capture_reached", 32'(k >= 16), 32'd1);
    #2 rst = 1'b1;
    #1;
    d0 = done_cnt;
    check("rst_mid_capture", 32'({bus.SS_n, bus.busy, bus.done, bus.rdata_valid, bus.rdata}), 32'(12'h800));
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Random regression: addresses kept in 0..7 so reads hit written locations.
    a0 = accepts;
    n = 0;
    while ((accepts - a0) < 3000 && n < 80000) begin
      bus.start = ($urandom_range(0, 3) != 0);
      bus.cmd   = 2'($urandom_range(0, 3));
      bus.wdata = bus.cmd[0] ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("random_frames_applied", 32'((accepts - a0) >= 3000), 32'd1);
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
